// File: rtl/sym_dn_lut_loader_if.sv
// Word stream into the LUT loader: WORD_W-bit words over a valid/ready handshake.
interface sym_dn_lut_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/sym_dn_lut_loader.sv
// Write-side driver for the 128x1 decision-node LUT RAM: serializes incoming
// words LSB-first into one-bit RAM writes and flags busy/done to the decoder.
module sym_dn_lut_loader #(
  parameter int LUT_DEPTH = 128,
  parameter int ADDR_W    = 7,
  parameter int WORD_W    = 8
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              load_abort,
  sym_dn_lut_loader_if.slave word_if,
  output logic              lut_in,
  output logic [ADDR_W-1:0] write_addr,
  output logic              we,
  output logic              load_busy,
  output logic              load_done
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [BIT_W-1:0]  r_bit;
  logic [ADDR_W-1:0] r_addr;
  logic              r_lut_in;
  logic [ADDR_W-1:0] r_write_addr;
  logic              r_we;
  logic              r_busy;
  logic              r_done;

  logic              w_last_bit;
  logic              w_last_entry;
  logic              w_accept;
  logic [BIT_W-1:0]  w_next_bit;

  assign w_last_bit   = (r_state == S_WRITE) && (r_bit == BIT_W'(WORD_W - 1));
  assign w_last_entry = (r_write_addr == ADDR_W'(LUT_DEPTH - 1));
  assign w_next_bit   = r_bit + 1'b1;

  // Abort gates ready so a word offered alongside an abort is never consumed.
  assign word_if.word_ready = !load_abort &&
                              ((r_state == S_FETCH) || (w_last_bit && !w_last_entry));
  assign w_accept = word_if.word_valid && word_if.word_ready;

  assign lut_in     = r_lut_in;
  assign write_addr = r_write_addr;
  assign we         = r_we;
  assign load_busy  = r_busy;
  assign load_done  = r_done;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_bit        <= '0;
      r_addr       <= '0;
      r_lut_in     <= 1'b0;
      r_write_addr <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (load_abort) begin
      r_state      <= S_IDLE;
      r_bit        <= '0;
      r_addr       <= '0;
      r_write_addr <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            r_state      <= S_WRITE;
            r_word       <= word_if.word_in;
            r_bit        <= '0;
            r_we         <= 1'b1;
            r_write_addr <= r_addr;
            r_lut_in     <= word_if.word_in[0];
            r_addr       <= r_addr + 1'b1;
          end
        end
        S_WRITE: begin
          if (w_last_bit) begin
            if (w_last_entry) begin
              r_state <= S_DONE;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_accept) begin
              r_word       <= word_if.word_in;
              r_bit        <= '0;
              r_write_addr <= r_addr;
              r_lut_in     <= word_if.word_in[0];
              r_addr       <= r_addr + 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_we    <= 1'b0;
            end
          end else begin
            r_bit        <= w_next_bit;
            r_write_addr <= r_addr;
            r_lut_in     <= r_word[w_next_bit];
            r_addr       <= r_addr + 1'b1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_write_addr <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
